// File: rtl/aes128_key_scheduler.sv
// AES-128 key expansion: one round per clock into an 11-entry round-key store,
// with a random-access read port that is either registered or combinational.
module aes128_key_scheduler #(
    parameter int OUT_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         busy,
    output logic         keys_valid
);

    // Byte i of the key sits at bits [8i+7:8i]; within a word the first FIPS byte is the LSB.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_t;

    state_t       r_state;
    logic [3:0]   r_count;
    logic [7:0]   r_rcon;
    logic         r_key_ready;
    logic         r_busy;
    logic         r_keys_valid;
    logic [127:0] r_store [0:10];

    logic         w_handshake;
    logic [127:0] w_prev;
    logic [127:0] w_next;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_temp;
    logic [7:0]   w_rcon_next;
    logic [127:0] w_rk_sel;

    assign w_handshake = key_valid && r_key_ready;

    // Previous round key; the guard keeps the index inside the store.
    always_comb begin
        w_prev = '0;
        for (int i = 1; i <= 10; i++) begin
            if (r_count == 4'(i)) begin
                w_prev = r_store[i-1];
            end
        end
    end

    assign w_rot = {w_prev[103:96], w_prev[127:104]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub[8*gi +: 8] = SBOX[w_rot[8*gi +: 8]];
        end
    endgenerate

    assign w_temp = w_sub ^ {24'h000000, r_rcon};

    // Word j of the next key is temp XOR the first j+1 words of the previous key.
    always_comb begin
        logic [31:0] acc;
        acc    = w_temp;
        w_next = '0;
        for (int j = 0; j < 4; j++) begin
            acc              = acc ^ w_prev[32*j +: 32];
            w_next[32*j +: 32] = acc;
        end
    end

    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_count      <= 4'd0;
            r_rcon       <= 8'h01;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_handshake) begin
                        r_state      <= ST_EXPAND;
                        r_count      <= 4'd1;
                        r_rcon       <= 8'h01;
                        r_key_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_keys_valid <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    r_count <= r_count + 4'd1;
                    r_rcon  <= w_rcon_next;
                    if (r_count == 4'd10) begin
                        r_state      <= ST_DONE;
                        r_key_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_keys_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_key_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_keys_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_handshake) begin
            r_store[0] <= key_in;
        end else if (r_state == ST_EXPAND) begin
            r_store[r_count] <= w_next;
        end
    end

    always_comb begin
        w_rk_sel = '0;
        for (int i = 0; i <= 10; i++) begin
            if (rk_idx == 4'(i)) begin
                w_rk_sel = r_store[i];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [127:0] r_rk_out;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rk_out <= '0;
                end else begin
                    r_rk_out <= w_rk_sel;
                end
            end
            assign rk_out = r_rk_out;
        end else begin : g_out_comb
            assign rk_out = w_rk_sel;
        end
    endgenerate

    assign key_ready  = r_key_ready;
    assign busy       = r_busy;
    assign keys_valid = r_keys_valid;

endmodule

// File: doc/aes128_key_scheduler.md
AES128_KEY_SCHEDULER -- requirements
Module: aes128_key_scheduler

Interface
REQ-001 SHALL have parameter OUT_REG, default 1: 1 = registered round-key read port (1-cycle latency); 0 = combinational read port (0-cycle latency).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port key_in, input, 128, cipher key; FIPS-197 key byte i at bits [8i+7:8i].
REQ-005 SHALL have port key_valid, input, 1, key_in is valid.
REQ-006 SHALL have port key_ready, output, 1, scheduler can accept a key.
REQ-007 SHALL have port rk_idx, input, 4, round-key index to read (0..10).
REQ-008 SHALL have port rk_out, output, 128, round key selected by rk_idx, same byte order as key_in.
REQ-009 SHALL have port busy, output, 1, expansion in progress.
REQ-010 SHALL have port keys_valid, output, 1, all 11 round keys are stored and valid.

Function
REQ-011 SHALL hold an 11-entry x 128-bit round-key store, a 4-bit round counter, an 8-bit rcon register and a 3-state FSM: IDLE, EXPAND, DONE.
REQ-012 SHALL drive key_ready = 1 in IDLE and DONE, and 0 in EXPAND.
REQ-013 SHALL treat a cycle with key_valid && key_ready as a handshake; on that edge: store[0] <= key_in, counter <= 1, rcon <= 8'h01, keys_valid <= 0, state -> EXPAND.
REQ-014 SHALL, in EXPAND with counter r, write store[r] <= one AES-128 key-expansion round of store[r-1] on each edge.
- Round = RotWord/SubWord on word 3, XOR with rcon in byte 0 of the word, then chained word XORs per FIPS-197.
- One round per cycle; exactly one shared expansion round instance.
REQ-015 SHALL update rcon by GF(2^8) xtime each EXPAND cycle (reduction polynomial 8'h1b), giving 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-016 SHALL, on the edge writing store[10], go to DONE and set keys_valid = 1; handshake in cycle 0 gives keys_valid = 1 from cycle 11.
REQ-017 SHALL drive busy = 1 exactly in EXPAND.
REQ-018 SHALL ignore key_valid while in EXPAND; the key is neither consumed nor queued.
REQ-019 SHALL, on a handshake in DONE, overwrite the key set and restart per REQ-013; keys_valid falls on that edge.
REQ-020 SHALL drive rk_out = store[rk_idx] for rk_idx 0..10 and 128'h0 for rk_idx 11..15.
- OUT_REG=1: rk_out registered, reflecting rk_idx and store from the previous edge.
- OUT_REG=0: rk_out combinational.
REQ-021 SHALL allow reads in any state; reads during EXPAND return current store contents, which keys_valid=0 marks as not yet valid.
REQ-022 SHALL NOT modify store contents in IDLE or DONE except via a new handshake.

Reset
REQ-023 SHALL, with rst=1 at an edge: state -> IDLE, counter = 0, rcon = 8'h01, keys_valid = 0, busy = 0, key_ready = 1 from the next cycle, registered rk_out = 0, store cleared to 0.
REQ-024 SHALL let reset override everything, including mid-EXPAND and a coincident handshake: no key is accepted in a reset cycle.

Verification
REQ-025 Key 2b7e151628aed2a6abf7158809cf4f3c (FIPS byte order) -> keys_valid at cycle 11; rk_idx=1 gives a0fafe1788542cb123a339392a6c7605; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-026 During EXPAND, toggle key_valid with a different key -> key_ready=0 throughout, busy=1 for exactly 10 cycles, FIPS results unchanged.
REQ-027 In DONE, handshake with key 000102030405060708090a0b0c0d0e0f -> keys_valid drops next cycle, returns 11 cycles after the handshake, and round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-028 Assert rst at EXPAND counter=5 -> next cycle IDLE, busy=0, keys_valid=0, key_ready=1, rk_out=0 for every rk_idx.
REQ-029 Read rk_idx 11..15 in DONE -> rk_out=0; with OUT_REG=1, an rk_idx change appears on rk_out one cycle later; with OUT_REG=0, in the same cycle.
REQ-030 Back-to-back: key_valid held high continuously -> new key accepted on the first DONE cycle, giving one handshake every 11 cycles.
